btn_input_ctrl: RTL
===================

Name: btn_input_ctrl

Overview:
- Parametrised button front end for the game top level. Replaces per-button ad-hoc synchronisers.
- For NUM_BTN raw pushbutton inputs it performs:
  - 2-FF synchronisation;
  - per-channel counter debounce;
  - press/release pulse generation;
  - optional per-channel auto-repeat.
- Channels 0-3 feed a direction register with reversal rejection and fixed priority, consumed by the movement/image logic.

Parameters:
- NUM_BTN, 6, number of button channels; must be >= 4. Channels 0..3 = left, right, up, down; 4 = mode_pb, 5 = KeyEnc.
- DB_CYCLES, 16, consecutive stable synchronised cycles required to accept a level change; >= 2.
- REPEAT_DELAY, 64, cycles a button is held before the first auto-repeat pulse; > DB_CYCLES.
- REPEAT_PERIOD, 16, cycles between subsequent auto-repeat pulses; >= 2.
- DIR_RESET, 2'd1, direction after reset. Encoding: 0 = left, 1 = right, 2 = up, 3 = down.

Ports:
- hwclk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset. All state clears while reset = 0.
- btn_in  in  NUM_BTN  raw asynchronous button levels, 1 = pressed.
- repeat_en  in  NUM_BTN  per-channel auto-repeat enable; quasi-static.
- btn_level  out  NUM_BTN  debounced level.
- btn_press  out  NUM_BTN  one-cycle pulse on accepted press or auto-repeat.
- btn_release  out  NUM_BTN  one-cycle pulse on accepted release.
- dir  out  2  current direction.
- dir_valid  out  1  one-cycle pulse when a direction press is accepted.

Behaviour:
- Reset values: btn_level = 0, btn_press = 0, btn_release = 0, dir = DIR_RESET, dir_valid = 0. Sync flops, debounce counters and repeat counters = 0.
- Sync: btn_in passes through two flops to give s[i]. No logic sits between the two flops.
- Debounce, per channel:
  - s[i] == btn_level[i]: debounce counter cleared.
  - s[i] != btn_level[i] and counter == DB_CYCLES-1: btn_level[i] toggles at the next edge and the counter clears.
  - Otherwise the counter increments.
  - A glitch shorter than DB_CYCLES synchronised cycles never changes btn_level.
- Latency: a clean step on btn_in changes btn_level exactly DB_CYCLES+2 rising edges after the first edge that samples it.
- Pulses:
  - btn_press[i] is registered and asserted in the same cycle btn_level[i] first reads 1.
  - btn_release[i] behaves the same on the transition to 0.
  - Each pulse lasts exactly one cycle.
- Auto-repeat, when repeat_en[i] = 1 and btn_level[i] = 1:
  - The repeat counter counts held cycles from the accepted press.
  - The first repeat btn_press pulse fires REPEAT_DELAY cycles after the initial press pulse.
  - Further pulses fire every REPEAT_PERIOD cycles while the button is held.
  - The counter clears on release, or when repeat_en[i] = 0 (no repeat pulses in that case).
- Direction logic, evaluated each cycle on btn_press[3:0]:
  - Candidate = lowest asserted index (left > right > up > down priority).
  - Opposite of the current dir = {0<->1, 2<->3}: rejected, no update, no dir_valid.
  - Otherwise dir <= candidate and dir_valid = 1 for one cycle, including when candidate == dir (repeat acceleration).
  - Latency: one cycle after btn_press.
- Simultaneous events:
  - Opposing candidate with lower priority than a legal one: the legal one wins, because priority is applied before the reversal check only among non-opposite requests.
  - Concretely, opposite requests are masked out first, then priority is applied.
  - Press on one channel concurrent with release on another: both pulses are independent.
- Channels >= 4 never affect dir.
- Reset mid-operation: asynchronous clear. Held buttons must re-satisfy the full debounce after reset deasserts, then produce a fresh press pulse.
- Counter widths: $clog2 of the respective parameter + 1. Counters saturate rather than wrap; the repeat counter reloads to 0 after each repeat pulse.

Test Plan (DB_CYCLES = 4, REPEAT_DELAY = 20, REPEAT_PERIOD = 5):
- Reset, then hold btn_in[1] high. Required: btn_level[1] rises exactly 6 edges later; btn_press[1] one cycle wide; dir stays 1 and dir_valid pulses once.
- 3-cycle pulse on btn_in[2]. Required: no change on btn_level, btn_press or dir. A 4-cycle stable pulse is accepted.
- dir = 1 (right), press left (ch 0). Required: rejected, dir = 1, no dir_valid. Then press up (ch 2): dir = 2 with a one-cycle dir_valid.
- dir = 2, press ch 0 and ch 3 simultaneously. Required: ch 3 (down) is masked as opposite, ch 0 is accepted, dir = 0.
- repeat_en[4] = 1, hold btn_in[4] for 40 cycles after acceptance. Required: btn_press[4] pulses at offsets 0, 20, 25, 30, 35. On release, btn_release[4] pulses exactly once after debounce.
- Hold btn_in[3], drive reset low mid-hold for 2 cycles. Required: all outputs cleared immediately and dir = 1. After release, btn_level[3] rises 6 edges later with a fresh press pulse.

Source files
------------

// File: rtl/btn_input_ctrl.sv
// Pushbutton front end: 2-FF sync, counter debounce, press/release/auto-repeat pulses,
// and a direction register fed from channels 0..3 that rejects direct reversals.
module btn_input_ctrl #(
  parameter int         NUM_BTN       = 6,
  parameter int         DB_CYCLES     = 16,
  parameter int         REPEAT_DELAY  = 64,
  parameter int         REPEAT_PERIOD = 16,
  parameter logic [1:0] DIR_RESET     = 2'd1
) (
  input  logic               hwclk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic [NUM_BTN-1:0] repeat_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [1:0]         dir,
  output logic               dir_valid
);

  localparam int DB_W    = $clog2(DB_CYCLES) + 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_SAT   = {DB_W{1'b1}};
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_SAT  = {RPT_W{1'b1}};

  logic [NUM_BTN-1:0] sync1_q, sync1_d;
  logic [NUM_BTN-1:0] sync2_q, sync2_d;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic [NUM_BTN-1:0] rpt_armed_q, rpt_armed_d;
  logic [DB_W-1:0]    db_cnt_q  [NUM_BTN];
  logic [DB_W-1:0]    db_cnt_d  [NUM_BTN];
  logic [RPT_W-1:0]   rpt_cnt_q [NUM_BTN];
  logic [RPT_W-1:0]   rpt_cnt_d [NUM_BTN];
  logic [1:0]         dir_q, dir_d;
  logic               dir_vld_q, dir_vld_d;
  logic [1:0]         opp_dir;
  logic [3:0]         dir_req;

  always_comb begin
    sync1_d     = btn_in;
    sync2_d     = sync1_q;
    level_d     = level_q;
    press_d     = '0;
    release_d   = '0;
    rpt_armed_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_d[i]  = '0;
      rpt_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = ~level_q[i];
        end else if (db_cnt_q[i] != DB_SAT) begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
      press_d[i]   = level_d[i] & ~level_q[i];
      release_d[i] = ~level_d[i] & level_q[i];
      // A repeat that would coincide with the release edge is dropped.
      if (repeat_en[i] && level_q[i] && level_d[i]) begin
        rpt_armed_d[i] = rpt_armed_q[i];
        if (rpt_cnt_q[i] == (rpt_armed_q[i] ? PER_LAST : DLY_LAST)) begin
          press_d[i]     = 1'b1;
          rpt_armed_d[i] = 1'b1;
        end else if (rpt_cnt_q[i] != RPT_SAT) begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
        end
      end
    end
  end

  // Opposite requests are masked before priority so a legal lower-priority press still wins.
  always_comb begin
    opp_dir   = {dir_q[1], ~dir_q[0]};
    dir_req   = press_q[3:0] & ~(4'b0001 << opp_dir);
    dir_d     = dir_q;
    dir_vld_d = 1'b0;
    if (dir_req[0]) begin
      dir_d     = 2'd0;
      dir_vld_d = 1'b1;
    end else if (dir_req[1]) begin
      dir_d     = 2'd1;
      dir_vld_d = 1'b1;
    end else if (dir_req[2]) begin
      dir_d     = 2'd2;
      dir_vld_d = 1'b1;
    end else if (dir_req[3]) begin
      dir_d     = 2'd3;
      dir_vld_d = 1'b1;
    end
  end

  always_ff @(posedge hwclk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      rpt_armed_q <= '0;
      dir_q       <= DIR_RESET;
      dir_vld_q   <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i]  <= '0;
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      rpt_armed_q <= rpt_armed_d;
      dir_q       <= dir_d;
      dir_vld_q   <= dir_vld_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign dir         = dir_q;
  assign dir_valid   = dir_vld_q;

endmodule
